// File: rtl/key_scan.sv
// 4x4 keypad scanner: one-cold row strobes, whole-frame debounce, one event per press.
// Optional held-key auto-repeat is built when KEY_SCAN_REPEAT_EN is defined.
module key_scan #(
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_FRAMES   = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic [3:0] COL,
  output logic [3:0] ROW,
  output logic [3:0] KEY,
  output logic       VALID,
  output logic       PRESSED
);

  typedef enum logic [1:0] {S_IDLE, S_DEB, S_HELD, S_REL} state_t;

  localparam logic [3:0] DEB_N = 4'(DEBOUNCE_FRAMES);

  logic [1:0] scan_q, scan_d;
  logic [1:0] acc_cnt_q, acc_cnt_d;
  logic [3:0] acc_code_q, acc_code_d;
  logic [1:0] frm_cnt_q, frm_cnt_d;
  logic [3:0] frm_code_q, frm_code_d;
  logic       frm_vld_q, frm_vld_d;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] key_q, key_d;
  logic       valid_q, valid_d;
  logic       pressed_q, pressed_d;
`ifdef KEY_SCAN_REPEAT_EN
  localparam logic [7:0] REP_N = 8'(REPEAT_FRAMES);
  logic [7:0] rep_q, rep_d;
  logic [7:0] rep_inc;
`endif

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [1:0] first_col(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  logic [3:0] hit;
  logic [2:0] row_keys;
  logic [2:0] sum;
  logic [1:0] merged_cnt;
  logic [3:0] merged_code;
  logic [3:0] cnt_inc;

  assign ROW     = ~(4'b0001 << scan_q);
  assign KEY     = key_q;
  assign VALID   = valid_q;
  assign PRESSED = pressed_q;

  // Fold the row being sampled into the running frame accumulator.
  always_comb begin
    hit         = ~COL;
    row_keys    = popcnt4(hit);
    sum         = {1'b0, acc_cnt_q} + row_keys;
    merged_cnt  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    merged_code = acc_code_q;
    if (acc_cnt_q == 2'd0 && row_keys != 3'd0)
      merged_code = {scan_q, first_col(hit)};
  end

  always_comb begin
    scan_d     = scan_q;
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    frm_cnt_d  = frm_cnt_q;
    frm_code_d = frm_code_q;
    frm_vld_d  = 1'b0;
    if (ENABLE) begin
      scan_d = scan_q + 2'd1;
      if (scan_q == 2'd3) begin
        frm_cnt_d  = merged_cnt;
        frm_code_d = merged_code;
        frm_vld_d  = 1'b1;
        acc_cnt_d  = 2'd0;
        acc_code_d = 4'd0;
      end else begin
        acc_cnt_d  = merged_cnt;
        acc_code_d = merged_code;
      end
    end
  end

  // Press/release state machine, evaluated once per registered frame.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    key_d     = key_q;
    valid_d   = 1'b0;
    pressed_d = pressed_q;
    cnt_inc   = cnt_q + 4'd1;
`ifdef KEY_SCAN_REPEAT_EN
    rep_d     = rep_q;
    rep_inc   = rep_q + 8'd1;
`endif
    if (frm_vld_q) begin
      case (state_q)
        S_IDLE: begin
          if (frm_cnt_q == 2'd1) begin
            cand_d = frm_code_q;
            if (4'd1 >= DEB_N) begin
              key_d     = frm_code_q;
              valid_d   = 1'b1;
              pressed_d = 1'b1;
              cnt_d     = 4'd0;
              state_d   = S_HELD;
            end else begin
              cnt_d   = 4'd1;
              state_d = S_DEB;
            end
          end
        end
        S_DEB: begin
          if (frm_cnt_q == 2'd1 && frm_code_q == cand_q) begin
            if (cnt_inc >= DEB_N) begin
              key_d     = cand_q;
              valid_d   = 1'b1;
              pressed_d = 1'b1;
              cnt_d     = 4'd0;
              state_d   = S_HELD;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (frm_cnt_q == 2'd1) begin
            cand_d = frm_code_q;
            cnt_d  = 4'd1;
          end else begin
            cnt_d   = 4'd0;
            state_d = S_IDLE;
          end
        end
        S_HELD: begin
          if (frm_cnt_q == 2'd0) begin
`ifdef KEY_SCAN_REPEAT_EN
            rep_d = 8'd0;
`endif
            if (4'd1 >= DEB_N) begin
              pressed_d = 1'b0;
              cnt_d     = 4'd0;
              state_d   = S_IDLE;
            end else begin
              cnt_d   = 4'd1;
              state_d = S_REL;
            end
          end else begin
`ifdef KEY_SCAN_REPEAT_EN
            if (frm_code_q == key_q) begin
              if (rep_inc >= REP_N) begin
                valid_d = 1'b1;
                rep_d   = 8'd0;
              end else begin
                rep_d = rep_inc;
              end
            end
`endif
          end
        end
        default: begin
          if (frm_cnt_q == 2'd0) begin
            if (cnt_inc >= DEB_N) begin
              pressed_d = 1'b0;
              cnt_d     = 4'd0;
              state_d   = S_IDLE;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d   = 4'd0;
            state_d = S_HELD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      scan_q     <= 2'd0;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= 4'd0;
      frm_cnt_q  <= 2'd0;
      frm_code_q <= 4'd0;
      frm_vld_q  <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      cand_q     <= 4'd0;
      key_q      <= 4'd0;
      valid_q    <= 1'b0;
      pressed_q  <= 1'b0;
`ifdef KEY_SCAN_REPEAT_EN
      rep_q      <= 8'd0;
`endif
    end else begin
      scan_q     <= scan_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
      frm_cnt_q  <= frm_cnt_d;
      frm_code_q <= frm_code_d;
      frm_vld_q  <= frm_vld_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      key_q      <= key_d;
      valid_q    <= valid_d;
      pressed_q  <= pressed_d;
`ifdef KEY_SCAN_REPEAT_EN
      rep_q      <= rep_d;
`endif
    end
  end

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan: keypad model drives COL from ROW and the held-key mask.
module tb_key_scan;
  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       ENABLE = 1'b0;
  logic [3:0] COL;
  logic [3:0] ROW;
  logic [3:0] KEY;
  logic       VALID;
  logic       PRESSED;

  logic [15:0] keys = 16'h0000;
  int total = 0;
  int bad = 0;
  int vcount = 0;
  logic [3:0] vkey = 4'd0;

  key_scan #(.DEBOUNCE_FRAMES(4), .REPEAT_FRAMES(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .COL(COL),
    .ROW(ROW), .KEY(KEY), .VALID(VALID), .PRESSED(PRESSED)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    COL = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!ROW[r] && keys[r*4+c]) COL[c] = 1'b0;
  end

  always @(negedge CLK) begin
    if (VALID) begin
      vcount = vcount + 1;
      vkey   = KEY;
    end
  end

  task automatic tick();
    @(negedge CLK) ENABLE = 1'b1;
    @(negedge CLK) ENABLE = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) repeat (4) tick();
  endtask

  task automatic test_reset();
    logic [3:0] exp_row [4];
    exp_row[0] = 4'b1101; exp_row[1] = 4'b1011; exp_row[2] = 4'b0111; exp_row[3] = 4'b1110;
    repeat (3) @(negedge CLK);
    total++; if (ROW !== 4'b1110) begin $display("FAIL reset_row got=%b exp=1110", ROW); bad++; end
    total++; if (KEY !== 4'd0) begin $display("FAIL reset_key got=%0d exp=0", KEY); bad++; end
    total++; if (VALID !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", VALID); bad++; end
    total++; if (PRESSED !== 1'b0) begin $display("FAIL reset_pressed got=%b exp=0", PRESSED); bad++; end
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (ROW !== exp_row[i]) begin $display("FAIL row_walk%0d got=%b exp=%b", i, ROW, exp_row[i]); bad++; end
    end
  endtask

  task automatic test_clean_press();
    int base = vcount;
    keys = 16'h0001 << 9;
    frames(3);
    total++; if (vcount - base !== 0) begin $display("FAIL press_early got=%0d exp=0", vcount - base); bad++; end
    total++; if (PRESSED !== 1'b0) begin $display("FAIL press_early_pr got=%b exp=0", PRESSED); bad++; end
    frames(1);
    total++; if (vcount - base !== 1) begin $display("FAIL press_accept got=%0d exp=1", vcount - base); bad++; end
    total++; if (vkey !== 4'd9) begin $display("FAIL press_key got=%0d exp=9", vkey); bad++; end
    total++; if (PRESSED !== 1'b1) begin $display("FAIL press_pr got=%b exp=1", PRESSED); bad++; end
    frames(2);
    total++; if (vcount - base !== 1) begin $display("FAIL press_single got=%0d exp=1", vcount - base); bad++; end
    keys = 16'h0000;
    frames(3);
    total++; if (PRESSED !== 1'b1) begin $display("FAIL rel_deb_pr got=%b exp=1", PRESSED); bad++; end
    frames(1);
    total++; if (PRESSED !== 1'b0) begin $display("FAIL rel_pr got=%b exp=0", PRESSED); bad++; end
    total++; if (KEY !== 4'd9) begin $display("FAIL rel_key_hold got=%0d exp=9", KEY); bad++; end
  endtask

  task automatic test_bounce();
    int base = vcount;
    keys = 16'h0001 << 5; frames(2);
    keys = 16'h0000;      frames(1);
    keys = 16'h0001 << 5; frames(2);
    keys = 16'h0000;      frames(1);
    total++; if (vcount - base !== 0) begin $display("FAIL bounce_valid got=%0d exp=0", vcount - base); bad++; end
    total++; if (PRESSED !== 1'b0) begin $display("FAIL bounce_pr got=%b exp=0", PRESSED); bad++; end
  endtask

  task automatic test_ghost_and_early_release();
    int base = vcount;
    keys = 16'h8001;
    frames(8);
    total++; if (vcount - base !== 0) begin $display("FAIL ghost_valid got=%0d exp=0", vcount - base); bad++; end
    total++; if (PRESSED !== 1'b0) begin $display("FAIL ghost_pr got=%b exp=0", PRESSED); bad++; end
    keys = 16'h0001;
    frames(3);
    total++; if (vcount - base !== 0) begin $display("FAIL early_rel_pre got=%0d exp=0", vcount - base); bad++; end
    frames(1);
    total++; if (vcount - base !== 1) begin $display("FAIL early_rel_valid got=%0d exp=1", vcount - base); bad++; end
    total++; if (vkey !== 4'd0) begin $display("FAIL early_rel_key got=%0d exp=0", vkey); bad++; end
    keys = 16'h0000;
    frames(4);
    total++; if (PRESSED !== 1'b0) begin $display("FAIL early_rel_done got=%b exp=0", PRESSED); bad++; end
  endtask

  task automatic test_freeze();
    int base = vcount;
    keys = 16'h0001 << 6;
    frames(2);
    tick();
    repeat (100) @(negedge CLK);
    total++; if (ROW !== 4'b1101) begin $display("FAIL freeze_row got=%b exp=1101", ROW); bad++; end
    total++; if (PRESSED !== 1'b0) begin $display("FAIL freeze_pr got=%b exp=0", PRESSED); bad++; end
    total++; if (vcount - base !== 0) begin $display("FAIL freeze_valid got=%0d exp=0", vcount - base); bad++; end
    repeat (3) tick();
    total++; if (vcount - base !== 0) begin $display("FAIL freeze_f3 got=%0d exp=0", vcount - base); bad++; end
    frames(1);
    total++; if (vcount - base !== 1) begin $display("FAIL freeze_accept got=%0d exp=1", vcount - base); bad++; end
    total++; if (vkey !== 4'd6) begin $display("FAIL freeze_key got=%0d exp=6", vkey); bad++; end
    keys = 16'h0000;
    frames(4);
  endtask

  task automatic test_repeat();
    int base;
    int exp16, exp32;
`ifdef KEY_SCAN_REPEAT_EN
    exp16 = 2; exp32 = 3;
`else
    exp16 = 1; exp32 = 1;
`endif
    base = vcount;
    keys = 16'h0001 << 3;
    frames(4);
    total++; if (vcount - base !== 1) begin $display("FAIL rep_accept got=%0d exp=1", vcount - base); bad++; end
    frames(15);
    total++; if (vcount - base !== 1) begin $display("FAIL rep_f15 got=%0d exp=1", vcount - base); bad++; end
    frames(1);
    total++; if (vcount - base !== exp16) begin $display("FAIL rep_f16 got=%0d exp=%0d", vcount - base, exp16); bad++; end
    frames(16);
    total++; if (vcount - base !== exp32) begin $display("FAIL rep_f32 got=%0d exp=%0d", vcount - base, exp32); bad++; end
    frames(8);
    total++; if (vcount - base !== exp32) begin $display("FAIL rep_f40 got=%0d exp=%0d", vcount - base, exp32); bad++; end
    total++; if (vkey !== 4'd3) begin $display("FAIL rep_key got=%0d exp=3", vkey); bad++; end
  endtask

  task automatic test_reset_mid();
    int base;
    repeat (2) tick();
    @(negedge CLK) RESET_N = 1'b0;
    #1;
    total++; if (ROW !== 4'b1110) begin $display("FAIL midrst_row got=%b exp=1110", ROW); bad++; end
    total++; if (KEY !== 4'd0) begin $display("FAIL midrst_key got=%0d exp=0", KEY); bad++; end
    total++; if (PRESSED !== 1'b0) begin $display("FAIL midrst_pr got=%b exp=0", PRESSED); bad++; end
    total++; if (VALID !== 1'b0) begin $display("FAIL midrst_valid got=%b exp=0", VALID); bad++; end
    keys = 16'h0000;
    @(negedge CLK) RESET_N = 1'b1;
    base = vcount;
    frames(1);
    total++; if (ROW !== 4'b1110) begin $display("FAIL postrst_row got=%b exp=1110", ROW); bad++; end
    total++; if (vcount - base !== 0) begin $display("FAIL postrst_valid got=%0d exp=0", vcount - base); bad++; end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_ghost_and_early_release();
    test_freeze();
    test_repeat();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
